// File: rtl/prog_loader_pkg.sv
// Shared widths, loader state encoding and the word-count clamp for the program loader.
package prog_loader_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 8;
  localparam int BYTE_W    = 8;
  localparam int MEM_DEPTH = 256;
  localparam int CNT_W     = ADDR_W + 1;

  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_B0,
    S_GET_B1,
    S_WRITE,
    S_GET_C0,
    S_GET_C1,
    S_CHECK,
    S_FIN
  } loader_state_e;

  // A load can never cover more than the whole memory.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] count);
    return (count > MAX_WORDS) ? MAX_WORDS : count;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Control, byte-stream and memory-write signals of the program loader.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic              start;
  logic [CNT_W-1:0]  word_count;
  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [DATA_W-1:0] mem_wd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_hold;

  modport master (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, mem_wd, mem_addr, mem_en, busy, done, err, cpu_hold
  );

  modport slave (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, mem_wd, mem_addr, mem_en, busy, done, err, cpu_hold
  );

endinterface

// File: rtl/prog_loader_byte_assembler.sv
// Packs two bytes into a 16-bit word: holds the first byte, merges the second as it arrives.
module prog_loader_byte_assembler
  import prog_loader_pkg::*;
#(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_first,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [DATA_W-1:0] word
);

  logic [BYTE_W-1:0] first_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= '0;
    end else if (load_first) begin
      first_q <= byte_in;
    end
  end

  // The word is complete in the cycle the second byte is on the bus.
  assign word = HI_FIRST ? {first_q, byte_in} : {byte_in, first_q};

endmodule

// File: rtl/prog_loader.sv
// Program loader: byte stream -> 16-bit words written sequentially to memory, then checksum verify.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00,
  parameter bit                HI_FIRST  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.master bus
);

  loader_state_e     state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] ck;
  logic [DATA_W-1:0] data_word;
  logic [DATA_W-1:0] ck_word;
  logic [DATA_W-1:0] mem_wd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic              done;
  logic              err;
  logic              accept;
  logic              xfer;
  logic              idle_or_fin;

  assign accept      = (state == S_GET_B0) || (state == S_GET_B1) ||
                       (state == S_GET_C0) || (state == S_GET_C1);
  assign xfer        = accept && bus.byte_valid;
  assign idle_or_fin = (state == S_IDLE) || (state == S_FIN);

  prog_loader_byte_assembler #(.HI_FIRST(HI_FIRST)) u_data_asm (
    .clk        (clk),
    .rst        (rst),
    .load_first (state == S_GET_B0 && xfer),
    .byte_in    (bus.byte_in),
    .word       (data_word)
  );

  prog_loader_byte_assembler #(.HI_FIRST(HI_FIRST)) u_ck_asm (
    .clk        (clk),
    .rst        (rst),
    .load_first (state == S_GET_C0 && xfer),
    .byte_in    (bus.byte_in),
    .word       (ck_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_FIN: begin
        if (bus.start) begin
          state_next = (clamp_count(bus.word_count) == '0) ? S_GET_C0 : S_GET_B0;
        end
      end
      S_GET_B0: if (xfer) state_next = S_GET_B1;
      S_GET_B1: if (xfer) state_next = S_WRITE;
      S_WRITE:  state_next = (remaining != CNT_W'(1)) ? S_GET_B0 : S_GET_C0;
      S_GET_C0: if (xfer) state_next = S_GET_C1;
      S_GET_C1: if (xfer) state_next = S_CHECK;
      S_CHECK:  state_next = S_FIN;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= BASE_ADDR;
      remaining <= '0;
      sum       <= '0;
      ck        <= '0;
      mem_wd    <= '0;
      mem_addr  <= BASE_ADDR;
      mem_en    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_en <= (state == S_GET_B1) && xfer;
      if (idle_or_fin && bus.start) begin
        ptr       <= BASE_ADDR;
        remaining <= clamp_count(bus.word_count);
        sum       <= '0;
        done      <= 1'b0;
        err       <= 1'b0;
      end
      // Write port registers are loaded as WRITE is entered and hold until the next word.
      if (state == S_GET_B1 && xfer) begin
        mem_wd   <= data_word;
        mem_addr <= ptr;
      end
      if (state == S_WRITE) begin
        sum       <= sum + mem_wd;
        ptr       <= ptr + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
      if (state == S_GET_C1 && xfer) ck <= ck_word;
      if (state == S_CHECK) begin
        err  <= (ck != sum);
        done <= 1'b1;
      end
    end
  end

  assign bus.byte_ready = accept;
  assign bus.mem_wd     = mem_wd;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_en     = mem_en;
  assign bus.busy       = !idle_or_fin;
  assign bus.done       = done;
  assign bus.err        = err;
  assign bus.cpu_hold   = !((state == S_FIN) && !err);

endmodule
